// File: rtl/mem_access_unit_if.sv
// Load/store port bundle: datapath request/completion plus the word-addressed memory handshake.
// The master side issues requests and plays memory; the slave side is the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_ready, done, load_data, fault, fault_cause,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_ready, done, load_data, fault, fault_cause,
           mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU load/store port: one request at a time, memory signals held until mem_resp,
// load data lane-aligned and extended, faults reported without touching memory.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_FUNCT3   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] tmo_cnt;
  logic [31:0] load_data_q;
  logic        fault_q;
  logic [1:0]  cause_q;

  logic        accept;
  logic        busy;
  logic        bad_funct3;
  logic        bad_align;
  logic        tmo_expire;
  logic        req_ready_c;
  logic        done_c;
  logic        mem_read_c;
  logic        mem_write_c;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = !we;
      default:                funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Loads always fetch the whole word; only stores narrow the lane mask.
  function automatic logic [3:0] lane_mask(input logic we, input logic [2:0] f3,
                                           input logic [1:0] off);
    if (!we) begin
      lane_mask = 4'b1111;
    end else begin
      case (f3[1:0])
        2'b00:   lane_mask = 4'b0001 << off;
        2'b01:   lane_mask = 4'b0011 << off;
        default: lane_mask = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [31:0]        lane;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane   = rdata >> {off, 3'b000};
    lane_b = signed'(lane[7:0]);
    lane_h = signed'(lane[15:0]);
    case (f3)
      3'b000:  load_extract = 32'(lane_b);
      3'b001:  load_extract = 32'(lane_h);
      3'b100:  load_extract = {24'd0, lane[7:0]};
      3'b101:  load_extract = {16'd0, lane[15:0]};
      default: load_extract = lane;
    endcase
  endfunction

  assign accept     = (state == IDLE) && bus.req_valid;
  assign busy       = (state == RD) || (state == WR);
  assign bad_funct3 = !funct3_legal(bus.req_we, bus.req_funct3);
  assign bad_align  = misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign tmo_expire = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    done_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (bad_funct3 || bad_align) state_next = RESP;
          else if (bus.req_we)         state_next = WR;
          else                         state_next = RD;
        end
      end
      RD: begin
        mem_read_c = 1'b1;
        if (bus.mem_resp || tmo_expire) state_next = RESP;
      end
      WR: begin
        mem_write_c = 1'b1;
        if (bus.mem_resp || tmo_expire) state_next = RESP;
      end
      RESP: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // p0: request captured at accept, held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_p0 <= bus.req_funct3;
      addr_p0   <= bus.req_addr;
      wdata_p0  <= bus.req_wdata;
    end
  end

  // Completion: result registers change only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      if (busy) tmo_cnt <= tmo_cnt + 32'd1;
      else      tmo_cnt <= '0;

      if (accept && (bad_funct3 || bad_align)) begin
        fault_q <= 1'b1;
        cause_q <= bad_funct3 ? CAUSE_FUNCT3 : CAUSE_MISALIGN;
      end else if (busy && bus.mem_resp) begin
        fault_q <= 1'b0;
        cause_q <= CAUSE_NONE;
        if (state == RD) load_data_q <= load_extract(bus.mem_rdata, funct3_p0, addr_p0[1:0]);
      end else if (busy && tmo_expire) begin
        fault_q <= 1'b1;
        cause_q <= CAUSE_TIMEOUT;
      end
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.done            = done_c;
  assign bus.mem_read        = mem_read_c;
  assign bus.mem_write       = mem_write_c;
  assign bus.mem_address     = busy ? {addr_p0[31:2], 2'b00} : 32'd0;
  assign bus.mem_wdata       = (state == WR) ? (wdata_p0 << {addr_p0[1:0], 3'b000}) : 32'd0;
  assign bus.mem_byte_enable = busy ? lane_mask(state == WR, funct3_p0, addr_p0[1:0]) : 4'd0;
  assign bus.load_data       = load_data_q;
  assign bus.fault           = fault_q;
  assign bus.fault_cause     = cause_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected memory operations and
// completions; a memory model and a completion monitor pop and compare independently.
module tb_mem_access_unit;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] data;
    bit          chk_data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
  } mop_t;

  resp_t       resp_q[$];
  mop_t        mop_q[$];
  logic [31:0] mem [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic exp_resp(input logic fault, input logic [1:0] cause, input logic [31:0] data,
                          input bit chk_data);
    resp_t r;
    r.fault = fault; r.cause = cause; r.data = data; r.chk_data = chk_data;
    resp_q.push_back(r);
  endtask

  task automatic exp_mop(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input int lat);
    mop_t m;
    m.we = we; m.addr = addr; m.be = be; m.wdata = wdata; m.lat = lat;
    mop_q.push_back(m);
  endtask

  // Returns one cycle after the accepting edge (posedge + 1).
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    while (!bus.req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) fail("req_ready_wait");
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] waddr,
                      input int lat, input logic [31:0] data);
    exp_mop(1'b0, waddr, 4'b1111, 32'd0, lat);
    exp_resp(1'b0, 2'b00, data, 1'b1);
    issue(1'b0, f3, addr, 32'd0, 1'b0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] waddr, input logic [3:0] be,
                       input logic [31:0] lanes, input int lat, input bit hold);
    exp_mop(1'b1, waddr, be, lanes, lat);
    exp_resp(1'b0, 2'b00, 32'd0, 1'b0);
    issue(1'b1, f3, addr, wdata, hold);
  endtask

  task automatic bad(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [1:0] cause);
    exp_resp(1'b1, cause, 32'd0, 1'b0);
    issue(we, f3, addr, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || !bus.req_ready) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) fail("wait_idle_timeout");
  endtask

  initial begin : monitor
    resp_t e;
    logic  prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        check("done_width", prev_done, 1'b0);
        if (resp_q.size() == 0) begin
          fail("done_unexpected");
        end else begin
          e = resp_q.pop_front();
          check("fault", bus.fault, e.fault);
          check("fault_cause", bus.fault_cause, e.cause);
          if (e.chk_data) check("load_data", bus.load_data, e.data);
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin : mem_model
    mop_t cur;
    bit   active;
    bit   resp_pending;
    bit   stable_bad;
    logic prev_req;
    logic req;
    int   cyc;
    active = 0; resp_pending = 0; stable_bad = 0; prev_req = 1'b0; cyc = 0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      req = bus.mem_read | bus.mem_write;
      if (rst) begin
        active = 0;
        if (resp_pending) begin
          bus.mem_resp = 1'b0;
          resp_pending = 0;
        end
      end else if (resp_pending) begin
        bus.mem_resp = 1'b0;
        resp_pending = 0;
        check("req_drop_after_resp", req, 1'b0);
      end else begin
        if (bus.mem_read && bus.mem_write) fail("read_write_overlap");
        if (req && !prev_req) begin
          if (mop_q.size() == 0) begin
            fail("mem_access_unexpected");
          end else begin
            cur = mop_q.pop_front();
            check("mem_dir", bus.mem_write, cur.we);
            check("mem_address", bus.mem_address, cur.addr);
            check("mem_byte_enable", bus.mem_byte_enable, cur.be);
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
            active = 1; cyc = 0; stable_bad = 0;
          end
        end else if (!req && active) begin
          active = 0;
          check("timeout_req_cycles", cyc, TMO);
          check("stable", stable_bad, 1'b0);
        end
        if (active && req) begin
          cyc++;
          if (bus.mem_address !== cur.addr || bus.mem_byte_enable !== cur.be ||
              bus.mem_write !== cur.we || (cur.we && bus.mem_wdata !== cur.wdata))
            stable_bad = 1;
          if (cur.lat > 0 && cyc == cur.lat) begin
            bus.mem_rdata = mem[cur.addr[11:2]];
            if (cur.we)
              for (int b = 0; b < 4; b++)
                if (cur.be[b]) mem[cur.addr[11:2]][8*b +: 8] = cur.wdata[8*b +: 8];
            bus.mem_resp = 1'b1;
            resp_pending = 1;
            active = 0;
            check("stable", stable_bad, 1'b0);
          end
        end
      end
      prev_req = req;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "simulation time limit");
  end

  initial begin : stimulus
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[32'h100 >> 2] = 32'h8899_AABB;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    check("rst_fault_cause", bus.fault_cause, 2'b00);
    check("rst_load_data", bus.load_data, 32'd0);
    check("rst_mem_address", bus.mem_address, 32'd0);
    check("rst_mem_byte_enable", bus.mem_byte_enable, 4'd0);

    // Loads from 0x100 = 0x8899AABB, minimum latency on the first one.
    load(3'b000, 32'h103, 32'h100, 1, 32'hFFFF_FF88);
    @(negedge clk);
    check("lat_mem_read_after_accept", bus.mem_read, 1'b1);
    @(negedge clk);
    check("lat_done_after_resp", bus.done, 1'b1);
    load(3'b100, 32'h103, 32'h100, 3, 32'h0000_0088);
    load(3'b001, 32'h102, 32'h100, 2, 32'hFFFF_8899);
    load(3'b101, 32'h100, 32'h100, 1, 32'h0000_AABB);
    load(3'b010, 32'h100, 32'h100, 5, 32'h8899_AABB);
    load(3'b000, 32'h100, 32'h100, 1, 32'hFFFF_FFBB);
    load(3'b100, 32'h101, 32'h100, 2, 32'h0000_00AA);

    // Stores with lane shifting, read back.
    store(3'b001, 32'h202, 32'h0000_1234, 32'h200, 4'b1100, 32'h1234_0000, 25, 1'b0);
    store(3'b000, 32'h201, 32'h0000_00AB, 32'h200, 4'b0010, 32'h0000_AB00, 3, 1'b0);
    load(3'b010, 32'h200, 32'h200, 1, 32'h1234_AB00);
    load(3'b001, 32'h202, 32'h200, 2, 32'h0000_1234);
    load(3'b000, 32'h201, 32'h200, 1, 32'hFFFF_FFAB);

    // Faulted requests: done one cycle after accept, no memory traffic.
    wait_idle();
    bad(1'b0, 3'b010, 32'h101, 2'b01);
    @(negedge clk);
    check("fault_done_latency", bus.done, 1'b1);
    bad(1'b1, 3'b011, 32'h200, 2'b10);
    bad(1'b0, 3'b001, 32'h103, 2'b01);
    bad(1'b1, 3'b001, 32'h201, 2'b01);
    bad(1'b1, 3'b010, 32'h202, 2'b01);
    bad(1'b0, 3'b011, 32'h100, 2'b10);
    bad(1'b1, 3'b100, 32'h101, 2'b10);
    bad(1'b0, 3'b110, 32'h100, 2'b10);

    // Timeout, then a response landing on the last allowed cycle.
    exp_mop(1'b0, 32'h300, 4'b1111, 32'd0, -1);
    exp_resp(1'b1, 2'b11, 32'd0, 1'b0);
    issue(1'b0, 3'b010, 32'h300, 32'd0, 1'b0);
    load(3'b010, 32'h100, 32'h100, TMO, 32'h8899_AABB);

    // Reset in cycle 10 of a read.
    wait_idle();
    exp_mop(1'b0, 32'h100, 4'b1111, 32'd0, -1);
    issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_mem_read", bus.mem_read, 1'b0);
    check("midrst_req_ready", bus.req_ready, 1'b1);
    check("midrst_done", bus.done, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    load(3'b010, 32'h200, 32'h200, 4, 32'h1234_AB00);

    // Back-to-back store then load with req_valid held.
    store(3'b010, 32'h204, 32'hCAFE_F00D, 32'h204, 4'b1111, 32'hCAFE_F00D, 2, 1'b1);
    load(3'b010, 32'h204, 32'h204, 1, 32'hCAFE_F00D);

    wait_idle();
    repeat (4) @(posedge clk);
    check("mem_ops_outstanding", mop_q.size(), 0);
    check("resp_outstanding", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
